// File: rtl/qam16_pkg.sv
// Shared definitions for the 16-QAM slicer / BER checker: Gray level codes,
// FSM state encoding and a 4-bit popcount helper.
package qam16_pkg;

   localparam logic [1:0] GRAY_M3 = 2'b00;
   localparam logic [1:0] GRAY_M1 = 2'b01;
   localparam logic [1:0] GRAY_P1 = 2'b11;
   localparam logic [1:0] GRAY_P3 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ALIGN   = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/qam16_decision_slicer.sv
// Per-axis 16-QAM decision slicer (Gray coded). With QAM16_SLICER_ERR_EN defined it
// also reports the error between the sample and the ideal decided level.
module qam16_decision_slicer
   import qam16_pkg::*;
#(
   parameter logic signed [17:0] REF_LEVEL = 18'sd32768
) (
   input  logic signed [17:0] x_i,
`ifdef QAM16_SLICER_ERR_EN
   output logic signed [17:0] err_o,
`endif
   output logic [1:0]         code_o
);

   localparam logic signed [17:0] NEG_REF = -REF_LEVEL;

   // Values exactly on a threshold fall into the upper region.
   always_comb begin
      if (x_i >= REF_LEVEL) begin
         code_o = GRAY_P3;
      end else if (x_i >= 18'sd0) begin
         code_o = GRAY_P1;
      end else if (x_i >= NEG_REF) begin
         code_o = GRAY_M1;
      end else begin
         code_o = GRAY_M3;
      end
   end

`ifdef QAM16_SLICER_ERR_EN
   localparam logic signed [17:0] LVL1 = 18'(REF_LEVEL / 2);
   localparam logic signed [17:0] LVL3 = 18'((3 * REF_LEVEL) / 2);

   logic signed [17:0] level;

   // The true difference always fits in 18 bits, so wrap-around subtraction is exact.
   always_comb begin
      level = LVL1;
      case (code_o)
         GRAY_M3: level = -LVL3;
         GRAY_M1: level = -LVL1;
         GRAY_P1: level = LVL1;
         default: level = LVL3;
      endcase
   end

   assign err_o = x_i - level;
`endif

endmodule

// File: rtl/qam16_slicer_ber.sv
// 16-QAM receive slicer with delayed-reference bit/symbol error counting over a
// fixed window. Optional err_i/err_q outputs enabled by QAM16_SLICER_ERR_EN.
module qam16_slicer_ber
   import qam16_pkg::*;
#(
   parameter logic signed [17:0] REF_LEVEL   = 18'sd32768,
   parameter int                 MAX_DELAY   = 32,
   parameter int                 WINDOW_LOG2 = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clk_en,
   input  logic signed [17:0]     rx_i,
   input  logic signed [17:0]     rx_q,
   input  logic [3:0]             ref_sym,
   input  logic [4:0]             align_delay,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [3:0]             rx_sym,
`ifdef QAM16_SLICER_ERR_EN
   output logic signed [17:0]     err_i,
   output logic signed [17:0]     err_q,
`endif
   output logic [WINDOW_LOG2+2:0] bit_errs,
   output logic [WINDOW_LOG2:0]   sym_errs
);

   localparam int BIT_W = WINDOW_LOG2 + 3;
   localparam int SYM_W = WINDOW_LOG2 + 1;
   localparam int CNT_W = (WINDOW_LOG2 > 5) ? WINDOW_LOG2 : 5;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WINDOW_LOG2) - 1);

   logic [1:0] i_code, q_code;
   logic [3:0] rx_sym_q;
   logic [3:0] dline_q [MAX_DELAY];
   logic [3:0] ref_d;
   logic [3:0] sym_diff;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       delay_q, delay_d;
   logic [BIT_W-1:0] bit_acc_q, bit_acc_d, bit_errs_q, bit_errs_d;
   logic [SYM_W-1:0] sym_acc_q, sym_acc_d, sym_errs_q, sym_errs_d;

`ifdef QAM16_SLICER_ERR_EN
   logic signed [17:0] erri_w, errq_w, erri_q, errq_q;
`endif

   qam16_decision_slicer #(.REF_LEVEL(REF_LEVEL)) u_slice_i (
      .x_i    (rx_i),
`ifdef QAM16_SLICER_ERR_EN
      .err_o  (erri_w),
`endif
      .code_o (i_code)
   );

   qam16_decision_slicer #(.REF_LEVEL(REF_LEVEL)) u_slice_q (
      .x_i    (rx_q),
`ifdef QAM16_SLICER_ERR_EN
      .err_o  (errq_w),
`endif
      .code_o (q_code)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sym_q <= '0;
`ifdef QAM16_SLICER_ERR_EN
         erri_q   <= '0;
         errq_q   <= '0;
`endif
      end else if (clk_en) begin
         rx_sym_q <= {i_code, q_code};
`ifdef QAM16_SLICER_ERR_EN
         erri_q   <= erri_w;
         errq_q   <= errq_w;
`endif
      end
   end

   // Tap k holds the reference from k+1 enables ago, lining up with the registered decision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < MAX_DELAY; k++) begin
            dline_q[k] <= '0;
         end
      end else if (clk_en) begin
         dline_q[0] <= ref_sym;
         for (int k = 1; k < MAX_DELAY; k++) begin
            dline_q[k] <= dline_q[k-1];
         end
      end
   end

   assign ref_d    = dline_q[delay_q];
   assign sym_diff = rx_sym_q ^ ref_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         delay_q    <= '0;
         bit_acc_q  <= '0;
         sym_acc_q  <= '0;
         bit_errs_q <= '0;
         sym_errs_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         delay_q    <= delay_d;
         bit_acc_q  <= bit_acc_d;
         sym_acc_q  <= sym_acc_d;
         bit_errs_q <= bit_errs_d;
         sym_errs_q <= sym_errs_d;
      end
   end

   // Results are published on entry to DONE so they are valid while done is high.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      delay_d    = delay_q;
      bit_acc_d  = bit_acc_q;
      sym_acc_d  = sym_acc_q;
      bit_errs_d = bit_errs_q;
      sym_errs_d = sym_errs_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_ALIGN;
               delay_d   = align_delay;
               cnt_d     = '0;
               bit_acc_d = '0;
               sym_acc_d = '0;
            end
         end
         ST_ALIGN: begin
            if (clk_en) begin
               if (cnt_q == CNT_W'(delay_q)) begin
                  cnt_d   = '0;
                  state_d = ST_MEASURE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_MEASURE: begin
            if (clk_en) begin
               bit_acc_d = bit_acc_q + BIT_W'(popcount4(sym_diff));
               sym_acc_d = sym_acc_q + SYM_W'(sym_diff != 4'd0);
               if (cnt_q == LAST_CNT) begin
                  cnt_d      = '0;
                  state_d    = ST_DONE;
                  bit_errs_d = bit_acc_d;
                  sym_errs_d = sym_acc_d;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy     = (state_q == ST_ALIGN) || (state_q == ST_MEASURE);
   assign done     = (state_q == ST_DONE);
   assign rx_sym   = rx_sym_q;
   assign bit_errs = bit_errs_q;
   assign sym_errs = sym_errs_q;
`ifdef QAM16_SLICER_ERR_EN
   assign err_i    = erri_q;
   assign err_q    = errq_q;
`endif

endmodule

// File: tb/tb_qam16_slicer_ber.sv
// Self-checking bench for qam16_slicer_ber (WINDOW_LOG2=4) using a symbol-history
// reference model; err_i/err_q checked when QAM16_SLICER_ERR_EN is defined.
module tb_qam16_slicer_ber;

   localparam int W   = 4;
   localparam int A   = 16384;
   localparam int WIN = 1 << W;

   logic              clk = 1'b0;
   logic              reset, clk_en, start;
   logic signed [17:0] rx_i, rx_q;
   logic [3:0]        ref_sym;
   logic [4:0]        align_delay;
   logic              busy, done;
   logic [3:0]        rx_sym;
   logic [W+2:0]      bit_errs;
   logic [W:0]        sym_errs;
`ifdef QAM16_SLICER_ERR_EN
   logic signed [17:0] err_i, err_q;
`endif

   int total = 0;
   int bad   = 0;
   int refH [4096];
   int rxiH [4096];
   int rxqH [4096];
   int n      = 0;
   int mode   = 0;
   int lag    = 0;
   int manI   = 0;
   int manQ   = 0;
   int nStart = 0;
   int prevBit = 0;
   int prevSym = 0;

   always #5 clk = ~clk;

   qam16_slicer_ber #(
      .REF_LEVEL   (18'sd32768),
      .MAX_DELAY   (32),
      .WINDOW_LOG2 (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_en      (clk_en),
      .rx_i        (rx_i),
      .rx_q        (rx_q),
      .ref_sym     (ref_sym),
      .align_delay (align_delay),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .rx_sym      (rx_sym),
`ifdef QAM16_SLICER_ERR_EN
      .err_i       (err_i),
      .err_q       (err_q),
`endif
      .bit_errs    (bit_errs),
      .sym_errs    (sym_errs)
   );

   // Ideal mapper amplitude for a Gray axis code
   function automatic int lvl(input int code);
      case (code)
         0:       return -3 * A;
         1:       return -A;
         3:       return A;
         default: return 3 * A;
      endcase
   endfunction

   // Decision per the threshold rules (2A threshold, ties go upward)
   function automatic int decide(input int x);
      if (x >= 2 * A) return 2;
      if (x >= 0)     return 3;
      if (x >= -2 * A) return 1;
      return 0;
   endfunction

   task automatic step(input bit en);
      int r, src, ni, nq;
      clk_en = en;
      if (en) begin
         r   = int'($urandom_range(0, 15));
         refH[n] = r;
         src = (n - lag >= 0) ? refH[n - lag] : 0;
         ni  = int'($urandom_range(0, 2000)) - 1000;
         nq  = int'($urandom_range(0, 2000)) - 1000;
         case (mode)
            0: begin
               rxiH[n] = lvl(src >> 2) + ni;
               rxqH[n] = lvl(src & 3) + nq;
            end
            1: begin
               rxiH[n] = 3 * A;
               rxqH[n] = lvl(src & 3) + nq;
            end
            default: begin
               rxiH[n] = manI;
               rxqH[n] = manQ;
            end
         endcase
         ref_sym = 4'(r);
         rx_i    = 18'(rxiH[n]);
         rx_q    = 18'(rxqH[n]);
      end
      @(posedge clk);
      #1;
      if (en) n++;
   endtask

   task automatic prefill(input int cnt);
      for (int i = 0; i < cnt; i++) step(1'b1);
   endtask

   task automatic model(input int d, output int be, output int se);
      int diff;
      be = 0;
      se = 0;
      for (int m = nStart + d + 1; m <= nStart + d + WIN; m++) begin
         diff = ((decide(rxiH[m-1]) << 2) | decide(rxqH[m-1])) ^ refH[m-1-d];
         be += $countones(diff);
         if (diff != 0) se++;
      end
   endtask

   task automatic do_start(input int d);
      clk_en      = 1'b0;
      start       = 1'b1;
      align_delay = 5'(d);
      @(posedge clk);
      #1;
      start  = 1'b0;
      nStart = n;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL start_busy: got %b want 1", busy);
      end
   endtask

   // Runs one window; counts enables up to the done pulse and all done pulses seen
   task automatic run_window(input int d, input int pauseAt, input bit restart,
                             output int enAtDone, output int dones);
      int enCnt, pauseLeft, tail;
      bit seen, restarted;
      enCnt = 0; dones = 0; enAtDone = -1; tail = 0; seen = 0; restarted = 0;
      pauseLeft = (pauseAt >= 0) ? 100 : 0;
      for (int c = 0; c < 400 && tail < 8; c++) begin
         if (pauseLeft > 0 && enCnt == pauseAt) begin
            step(1'b0);
            pauseLeft--;
            if (pauseLeft == 0) begin
               total++;
               if (busy !== 1'b1 || bit_errs !== (W+3)'(prevBit) || sym_errs !== (W+1)'(prevSym)) begin
                  bad++;
                  $display("[TB] FAIL pause_hold: busy=%b bit=%0d sym=%0d want 1/%0d/%0d",
                           busy, bit_errs, sym_errs, prevBit, prevSym);
               end
            end
         end else if (restart && !restarted && enCnt == 3) begin
            clk_en      = 1'b0;
            start       = 1'b1;
            align_delay = 5'd9;
            @(posedge clk);
            #1;
            start     = 1'b0;
            restarted = 1'b1;
         end else begin
            step(1'b1);
            enCnt++;
         end
         if (done === 1'b1) begin
            dones++;
            if (!seen) enAtDone = enCnt;
            seen = 1'b1;
         end
         if (seen) tail++;
      end
   endtask

   task automatic check_window(input string name, input int d, input int enAtDone,
                               input int dones, input int be, input int se);
      total++;
      if (enAtDone != d + 1 + WIN) begin
         bad++;
         $display("[TB] FAIL %s_latency: got %0d enables want %0d", name, enAtDone, d + 1 + WIN);
      end
      total++;
      if (dones != 1) begin
         bad++;
         $display("[TB] FAIL %s_done_count: got %0d want 1", name, dones);
      end
      total++;
      if (bit_errs !== (W+3)'(be)) begin
         bad++;
         $display("[TB] FAIL %s_bit_errs: got %0d want %0d", name, bit_errs, be);
      end
      total++;
      if (sym_errs !== (W+1)'(se)) begin
         bad++;
         $display("[TB] FAIL %s_sym_errs: got %0d want %0d", name, sym_errs, se);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s_busy_end: got %b want 0", name, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; clk_en = 1'b0; start = 1'b0;
      rx_i = '0; rx_q = '0; ref_sym = '0; align_delay = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || rx_sym !== 4'd0 || bit_errs !== '0 || sym_errs !== '0) begin
         bad++;
         $display("[TB] FAIL reset_state: busy=%b done=%b rx_sym=%h bit=%0d sym=%0d want all 0",
                  busy, done, rx_sym, bit_errs, sym_errs);
      end
   endtask

   task automatic test_ideal();
      int en, dn, be, se;
      mode = 0; lag = 0;
      prefill(40);
      do_start(0);
      run_window(0, -1, 1'b0, en, dn);
      check_window("ideal", 0, en, dn, 0, 0);
   endtask

   task automatic test_delay();
      int en, dn, be, se;
      mode = 0; lag = 3;
      prefill(40);
      do_start(3);
      run_window(3, -1, 1'b0, en, dn);
      check_window("delay_match", 3, en, dn, 0, 0);
      do_start(2);
      run_window(2, -1, 1'b0, en, dn);
      model(2, be, se);
      check_window("delay_off", 2, en, dn, be, se);
   endtask

   task automatic test_const_i();
      int en, dn, be, se;
      mode = 1; lag = 0;
      prefill(40);
      do_start(1);
      run_window(1, -1, 1'b0, en, dn);
      model(1, be, se);
      check_window("const_i", 1, en, dn, be, se);
      total++;
      if (rx_sym[3:2] !== 2'b10) begin
         bad++;
         $display("[TB] FAIL const_i_code: got %b want 10", rx_sym[3:2]);
      end
      prevBit = be; prevSym = se;
   endtask

   task automatic test_threshold();
      int vals [6] = '{32768, 32767, 0, -1, -32768, -32769};
      logic [1:0] exps [6] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
      mode = 2;
      for (int i = 0; i < 6; i++) begin
         manI = vals[i];
         manQ = vals[5 - i];
         step(1'b1);
         total++;
         if (rx_sym[3:2] !== exps[i]) begin
            bad++;
            $display("[TB] FAIL thresh_i[%0d]: got %b want %b", vals[i], rx_sym[3:2], exps[i]);
         end
         total++;
         if (rx_sym[1:0] !== exps[5 - i]) begin
            bad++;
            $display("[TB] FAIL thresh_q[%0d]: got %b want %b", vals[5 - i], rx_sym[1:0], exps[5 - i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int en, dn, be, se;
      mode = 0; lag = 0;
      prefill(40);
      do_start(0);
      repeat (5) step(1'b1);
      total++;
      if (busy !== 1'b1 || bit_errs !== (W+3)'(prevBit) || sym_errs !== (W+1)'(prevSym)) begin
         bad++;
         $display("[TB] FAIL hold_in_measure: busy=%b bit=%0d sym=%0d want 1/%0d/%0d",
                  busy, bit_errs, sym_errs, prevBit, prevSym);
      end
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || rx_sym !== 4'd0 || bit_errs !== '0 || sym_errs !== '0) begin
         bad++;
         $display("[TB] FAIL reset_mid: busy=%b done=%b rx_sym=%h bit=%0d sym=%0d want all 0",
                  busy, done, rx_sym, bit_errs, sym_errs);
      end
      reset = 1'b1; start = 1'b1; clk_en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0; start = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_vs_start: busy=%b want 0", busy);
      end
      prefill(40);
      do_start(1);
      run_window(1, -1, 1'b1, en, dn);
      model(1, be, se);
      check_window("busy_restart", 1, en, dn, be, se);
      prevBit = be; prevSym = se;
   endtask

   task automatic test_freeze();
      int en, dn, be, se;
      mode = 0; lag = 2;
      prefill(40);
      do_start(2);
      run_window(2, 6, 1'b0, en, dn);
      model(2, be, se);
      check_window("freeze", 2, en, dn, be, se);
`ifdef QAM16_SLICER_ERR_EN
      mode = 2;
      manI = A + 5;
      manQ = -3 * A - 7;
      step(1'b1);
      total++;
      if (err_i !== 18'sd5 || err_q !== -18'sd7) begin
         bad++;
         $display("[TB] FAIL err_out: err_i=%0d err_q=%0d want 5/-7", err_i, err_q);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_delay();
      test_const_i();
      test_threshold();
      test_reset_mid();
      test_freeze();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
